// File: rtl/pipe_cnt_pkg.sv
// Shared types for the split-carry counter controller: command opcodes,
// FSM states and the half-width helper used by the datapath.
package pipe_cnt_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_LOAD = 2'd1,
        OP_RUN  = 2'd2,
        OP_STOP = 2'd3
    } cnt_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } cnt_state_e;

    function automatic int half_width(input int w);
        return w / 2;
    endfunction

endpackage

// File: rtl/pipe_cnt_ctrl_dp.sv
// Split-carry counter datapath: low half increments, its carry is registered
// and folded into the high half one cycle later; lo is delayed to stay aligned.
module split_inc_dp
    import pipe_cnt_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt_out,
    output logic             wrap
);
    localparam int HW = half_width(WIDTH);

    logic [HW-1:0] lo_q, lo_d_q, hi_q;
    logic          c_q, wrap_q;
    logic [HW:0]   lo_sum;

    assign lo_sum = {1'b0, lo_q} + (HW+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q   <= '0;
            lo_d_q <= '0;
            hi_q   <= '0;
            c_q    <= 1'b0;
            wrap_q <= 1'b0;
        end else if (load) begin
            lo_q   <= load_val[HW-1:0];
            lo_d_q <= load_val[HW-1:0];
            hi_q   <= load_val[WIDTH-1:HW];
            c_q    <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            if (en)
                lo_q <= lo_sum[HW-1:0];
            c_q    <= en & lo_sum[HW];
            lo_d_q <= lo_q;
            hi_q   <= hi_q + {{(HW-1){1'b0}}, c_q};
            // A pending carry means lo just rolled to zero; with hi all-ones
            // the aligned value becomes zero on this edge.
            wrap_q <= c_q & (&hi_q);
        end
    end

    assign cnt_out = {hi_q, lo_d_q};
    assign wrap    = wrap_q;

endmodule

// File: rtl/pipe_cnt_ctrl.sv
// Command FSM (LOAD/RUN/STOP) gating the split-carry counter enable.
// Optional PIPE_CNT_CTRL_STATS_EN adds a saturating enabled-cycle counter.
module pipe_cnt_ctrl
    import pipe_cnt_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] cnt_out,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             cmd_err
`ifdef PIPE_CNT_CTRL_STATS_EN
   ,output logic [31:0]      run_cycles
`endif
);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    cnt_state_e       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             stop_q, stop_d;
    logic             done_q, err_q, err_d;
    logic             en, load, acc;
    cnt_op_e          op;

    assign op        = cnt_op_e'(cmd_op);
    assign cmd_ready = !rst && (state_q != ST_DRAIN);
    assign acc       = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stop_d  = stop_q;
        err_d   = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc && op == OP_LOAD)
                    load = 1'b1;
                if (acc && op == OP_RUN) begin
                    if (cmd_data == '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        rem_d   = cmd_data;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // A stopped run spends one extra cycle in RUN with en gated off.
                if (stop_q) begin
                    stop_d  = 1'b0;
                    state_d = ST_DRAIN;
                end else begin
                    en    = 1'b1;
                    rem_d = rem_q - CNT_ONE;
                    if (rem_q == CNT_ONE)
                        state_d = ST_DRAIN;
                    else if (acc && op == OP_STOP)
                        stop_d = 1'b1;
                end
                if (acc && (op == OP_LOAD || op == OP_RUN))
                    err_d = 1'b1;
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            stop_q  <= stop_d;
            done_q  <= (state_q == ST_DRAIN);
            err_q   <= err_d;
        end
    end

    split_inc_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (cmd_data),
        .cnt_out  (cnt_out),
        .wrap     (wrap)
    );

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign cmd_err = err_q;

`ifdef PIPE_CNT_CTRL_STATS_EN
    logic [31:0] run_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            run_cycles_q <= '0;
        else if (en && run_cycles_q != '1)
            run_cycles_q <= run_cycles_q + 32'd1;
    end

    assign run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_cnt_ctrl.sv
// Directed bench for pipe_cnt_ctrl: vector table for single commands plus
// hand sequences for carry coherence, wrap, STOP, illegal commands and reset.
module tb_pipe_cnt_ctrl;
    import pipe_cnt_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [63:0] cmd_data;
    logic [63:0] cnt_out;
    logic        busy, done, wrap, cmd_err;
`ifdef PIPE_CNT_CTRL_STATS_EN
    logic [31:0] run_cycles;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int en_total = 0;

    pipe_cnt_ctrl #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cnt_out   (cnt_out),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .cmd_err   (cmd_err)
`ifdef PIPE_CNT_CTRL_STATS_EN
       ,.run_cycles(run_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [63:0] d);
        chk("ready_before_issue", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = '0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [63:0] data;
        int          lat;
        logic [63:0] exp_cnt;
        logic        exp_done;
    } vec_t;

    vec_t vt[11];

    initial begin
        logic [63:0] prev;
        int          steps, wraps, bad_seen;

        vt[0]  = '{OP_LOAD, 64'h10,                  1,  64'h10,                  1'b0};
        vt[1]  = '{OP_RUN,  64'd5,                   7,  64'h15,                  1'b1};
        vt[2]  = '{OP_RUN,  64'd0,                   2,  64'h15,                  1'b1};
        vt[3]  = '{OP_STOP, 64'd0,                   2,  64'h15,                  1'b0};
        vt[4]  = '{OP_NOP,  64'd0,                   1,  64'h15,                  1'b0};
        vt[5]  = '{OP_LOAD, 64'h1234_5678_9ABC_DEF0, 1,  64'h1234_5678_9ABC_DEF0, 1'b0};
        vt[6]  = '{OP_RUN,  64'd1,                   3,  64'h1234_5678_9ABC_DEF1, 1'b1};
        vt[7]  = '{OP_LOAD, 64'h0000_0000_FFFF_FFFF, 1,  64'h0000_0000_FFFF_FFFF, 1'b0};
        vt[8]  = '{OP_RUN,  64'd1,                   3,  64'h0000_0001_0000_0000, 1'b1};
        vt[9]  = '{OP_LOAD, 64'hFFFF_FFFF_0000_0000, 1,  64'hFFFF_FFFF_0000_0000, 1'b0};
        vt[10] = '{OP_RUN,  64'd16,                  18, 64'hFFFF_FFFF_0000_0010, 1'b1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
        #1;
        chk("rst_cnt",   cnt_out, 64'd0);
        chk("rst_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_done",  {63'd0, done}, 64'd0);
        chk("rst_wrap",  {63'd0, wrap}, 64'd0);
        chk("rst_err",   {63'd0, cmd_err}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("idle_ready", {63'd0, cmd_ready}, 64'd1);

        // Single-command vectors: done must stay low until exactly lat cycles.
        for (int i = 0; i < 11; i++) begin
            issue(vt[i].op, vt[i].data);
            for (int k = 1; k < vt[i].lat; k++) begin
                chk($sformatf("v%0d_early_done", i), {63'd0, done}, 64'd0);
                tick();
            end
            chk($sformatf("v%0d_cnt", i),   cnt_out, vt[i].exp_cnt);
            chk($sformatf("v%0d_done", i),  {63'd0, done}, {63'd0, vt[i].exp_done});
            chk($sformatf("v%0d_busy", i),  {63'd0, busy}, 64'd0);
            chk($sformatf("v%0d_ready", i), {63'd0, cmd_ready}, 64'd1);
            chk($sformatf("v%0d_err", i),   {63'd0, cmd_err}, 64'd0);
        end
        en_total += 5 + 1 + 1 + 16;

        // Half-carry crossing: every observed value must be a coherent step.
        issue(OP_LOAD, 64'h0000_0000_FFFF_FFFE);
        issue(OP_RUN, 64'd3);
        prev = 64'h0000_0000_FFFF_FFFE;
        steps = 0;
        for (int k = 1; k <= 5; k++) begin
            if (!(cnt_out == 64'h0000_0000_FFFF_FFFE || cnt_out == 64'h0000_0000_FFFF_FFFF ||
                  cnt_out == 64'h0000_0001_0000_0000 || cnt_out == 64'h0000_0001_0000_0001) ||
                cnt_out < prev)
                chk($sformatf("carry_coherent_k%0d", k), cnt_out, prev);
            if (cnt_out != prev) steps++;
            prev = cnt_out;
            if (k < 5) tick();
        end
        chk("carry_final", cnt_out, 64'h0000_0001_0000_0001);
        chk("carry_done",  {63'd0, done}, 64'd1);
        chk("carry_steps", 64'(steps), 64'd3);
        en_total += 3;

        // All-ones wrap: wrap exactly once, aligned with cnt_out == 0.
        issue(OP_LOAD, '1);
        issue(OP_RUN, 64'd2);
        wraps = 0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("wrap_align_k%0d", k), {63'd0, wrap}, {63'd0, cnt_out == 64'd0});
            if (wrap) wraps++;
            if (k < 4) tick();
        end
        chk("wrap_count", 64'(wraps), 64'd1);
        chk("wrap_final", cnt_out, 64'd1);
        chk("wrap_done",  {63'd0, done}, 64'd1);
        en_total += 2;

        // RUN 100, illegal RUN mid-run, STOP 10 cycles after the accept.
        issue(OP_LOAD, 64'h1000);
        issue(OP_RUN, 64'd100);
        repeat (3) tick();
        issue(OP_RUN, 64'd7);
        chk("err_pulse", {63'd0, cmd_err}, 64'd1);
        chk("err_busy",  {63'd0, busy}, 64'd1);
        tick();
        chk("err_clear", {63'd0, cmd_err}, 64'd0);
        repeat (4) tick();
        issue(OP_STOP, 64'd0);
        chk("stop_s1_done", {63'd0, done}, 64'd0);
        tick();
        chk("stop_s2_done",  {63'd0, done}, 64'd0);
        chk("stop_s2_busy",  {63'd0, busy}, 64'd1);
        chk("stop_s2_ready", {63'd0, cmd_ready}, 64'd0);
        tick();
        chk("stop_s3_done",  {63'd0, done}, 64'd1);
        chk("stop_s3_cnt",   cnt_out, 64'h100A);
        chk("stop_s3_busy",  {63'd0, busy}, 64'd0);
        chk("stop_s3_ready", {63'd0, cmd_ready}, 64'd1);
        tick();
        chk("stop_s4_done",  {63'd0, done}, 64'd0);
        en_total += 10;

        // STOP landing on the last counted cycle completes normally.
        issue(OP_LOAD, 64'd0);
        issue(OP_RUN, 64'd3);
        repeat (2) tick();
        issue(OP_STOP, 64'd0);
        chk("stoplast_t4_done", {63'd0, done}, 64'd0);
        tick();
        chk("stoplast_t5_done", {63'd0, done}, 64'd1);
        chk("stoplast_t5_cnt",  cnt_out, 64'd3);
        tick();
        chk("stoplast_t6_done", {63'd0, done}, 64'd0);
        en_total += 3;

        // Reset in the middle of a run.
        issue(OP_LOAD, 64'h50);
        issue(OP_RUN, 64'd20);
        repeat (4) tick();
        en_total += 4;
`ifdef PIPE_CNT_CTRL_STATS_EN
        chk("stats_total", {32'd0, run_cycles}, 64'(en_total));
`endif
        rst = 1'b1;
        #1;
        chk("midrst_cnt",   cnt_out, 64'd0);
        chk("midrst_busy",  {63'd0, busy}, 64'd0);
        chk("midrst_ready", {63'd0, cmd_ready}, 64'd0);
        chk("midrst_done",  {63'd0, done}, 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("postrst_ready", {63'd0, cmd_ready}, 64'd1);
        bad_seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (done || busy || cnt_out != 64'd0) bad_seen++;
            tick();
        end
        chk("postrst_quiet", 64'(bad_seen), 64'd0);
`ifdef PIPE_CNT_CTRL_STATS_EN
        chk("stats_after_rst", {32'd0, run_cycles}, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
